// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller.
//   run_state_t : controller state encoding (RUN / HALT / STEP)
//   TICK_W      : width of the issued-tick counter
package cpu_run_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } run_state_t;

   localparam int TICK_W = 16;

endpackage

// File: rtl/cpu_run_controller_button_debouncer.sv
// Button conditioning: 2-flop synchronizer, polarity normalisation and a
// stability counter, plus single-cycle edge events on the debounced level.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   button       : raw asynchronous button pin
//   pressed      : debounced level, 1 = pressed regardless of pin polarity
//   press_evt    : one cycle, first cycle that pressed reads 1
//   release_evt  : one cycle, first cycle that pressed reads 0
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES   = 8,
   parameter int BUTTON_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic pressed,
   output logic press_evt,
   output logic release_evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic RELEASED = (BUTTON_ACTIVE_LOW != 0);

   logic          sync_a;
   logic          sync_b;
   logic          sampled;
   logic [CW-1:0] stable_cnt;

   // XOR with the idle pin level turns the pin into "pressed = 1".
   assign sampled = sync_b ^ RELEASED;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a      <= RELEASED;
         sync_b      <= RELEASED;
         pressed     <= 1'b0;
         stable_cnt  <= '0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
      end else begin
         sync_a      <= button;
         sync_b      <= sync_a;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         if (sampled != pressed) begin
            // Accept the new level on the Nth consecutive disagreeing sample;
            // the event is registered alongside the level so both appear together.
            if (stable_cnt == CNT_LAST) begin
               pressed     <= sampled;
               stable_cnt  <= '0;
               press_evt   <= sampled;
               release_evt <= ~sampled;
            end else begin
               stable_cnt <= stable_cnt + 1'b1;
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// CPU run controller: turns one user button into a CPU clock-enable with
// RUN (divided rate), HALT and single-STEP modes.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   i_button      : raw button pin
//   o_cpu_en      : registered one-cycle CPU clock-enable pulse
//   o_halted      : 1 in HALT and STEP
//   o_pressed     : debounced pressed level
//   o_tick_count  : count of o_cpu_en pulses, wraps
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | divider free-runs, pulse every DIV cycles; release halts
// ST_HALT | no pulses; short press steps, long press resumes RUN
// ST_STEP | single pulse cycle, then back to HALT
module cpu_run_controller
   import cpu_run_controller_pkg::*;
#(
   parameter int DIV               = 4,
   parameter int DEBOUNCE_CYCLES   = 8,
   parameter int LONG_CYCLES       = 32,
   parameter int BUTTON_ACTIVE_LOW = 1,
   parameter int START_RUN         = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_button,
   output logic              o_cpu_en,
   output logic              o_halted,
   output logic              o_pressed,
   output logic [TICK_W-1:0] o_tick_count
);

   localparam int DW = $clog2(DIV);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam run_state_t    ST_INIT   = (START_RUN != 0) ? ST_RUN : ST_HALT;

   run_state_t    state;
   run_state_t    state_next;
   logic [DW-1:0] div_cnt;
   logic [HW-1:0] hold_cnt;
   logic          long_fired;
   logic          resume_hold;
   logic          press_evt;
   logic          release_evt;
   logic          long_evt;
   logic          div_tc;
   logic          cpu_en_next;

   button_debouncer #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW)
   ) u_debouncer (
      .clk         (clk),
      .reset       (reset),
      .button      (i_button),
      .pressed     (o_pressed),
      .press_evt   (press_evt),
      .release_evt (release_evt)
   );

   assign long_evt = o_pressed && (hold_cnt == HOLD_LAST) && !long_fired;
   assign div_tc   = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_INIT;
         o_cpu_en <= 1'b0;
      end else begin
         state    <= state_next;
         o_cpu_en <= cpu_en_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            // The release that ends a resuming long press must not halt again.
            if (release_evt && !resume_hold) state_next = ST_HALT;
         end
         ST_HALT: begin
            if (long_evt)                          state_next = ST_RUN;
            else if (release_evt && !long_fired)   state_next = ST_STEP;
         end
         ST_STEP: state_next = ST_HALT;
         default: state_next = ST_INIT;
      endcase
   end

   always_comb begin
      o_halted    = (state != ST_RUN);
      // A terminal count coinciding with a halting release still pulses.
      cpu_en_next = ((state == ST_RUN) && div_tc) ||
                    ((state == ST_HALT) && release_evt && !long_fired);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt      <= '0;
         hold_cnt     <= '0;
         long_fired   <= 1'b0;
         resume_hold  <= 1'b0;
         o_tick_count <= '0;
      end else begin
         // Divider only advances while staying in RUN, so every RUN entry starts at 0.
         if ((state == ST_RUN) && (state_next == ST_RUN))
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
         else
            div_cnt <= '0;

         if (!o_pressed)
            hold_cnt <= '0;
         else if (hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;

         if (release_evt || press_evt)
            long_fired <= 1'b0;
         else if (long_evt)
            long_fired <= 1'b1;

         if (release_evt)
            resume_hold <= 1'b0;
         else if ((state == ST_HALT) && long_evt)
            resume_hold <= 1'b1;

         o_tick_count <= o_tick_count + {{(TICK_W-1){1'b0}}, o_cpu_en};
      end
   end

endmodule
